// File: rtl/mips_regfile_mp.sv
// Parametrised MIPS register file with N async read ports and a hardware clear sequencer.
// Optional macro MIPS_REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module mips_regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_READ = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       RegWrite,
   input  logic [ADDR_W-1:0]          write_reg,
   input  logic [DATA_W-1:0]          write_data,
   input  logic [NUM_READ*ADDR_W-1:0] read_reg,
   output logic [NUM_READ*DATA_W-1:0] read_data,
   output logic                       init_busy,
   output logic                       clear_done
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_clr_idx;
   logic                r_busy;
   logic                r_done;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_we;
   logic [ADDR_W-1:0]   w_waddr;
   logic [DATA_W-1:0]   w_wdata;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_CLEAR;
         r_clr_idx <= '0;
         r_busy    <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_clr_idx <= r_clr_idx + 1'b1;
               if (r_clr_idx == {ADDR_W{1'b1}}) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_done <= 1'b0;
         endcase
      end
   end

   // The sequencer owns the single write port while clearing; the reset edge writes nothing.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = write_reg;
      w_wdata = write_data;
      if (!reset) begin
         if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_idx;
            w_wdata = '0;
         end else if (RegWrite && !((ZERO_REG != 0) && (write_reg == '0))) begin
            w_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_we)
         r_mem[w_waddr] <= w_wdata;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
         logic [ADDR_W-1:0] w_idx;
         logic              w_zero;
         logic              w_byp;

         assign w_idx  = read_reg[gi*ADDR_W +: ADDR_W];
         assign w_zero = (ZERO_REG != 0) && (w_idx == '0);
`ifdef MIPS_REGFILE_BYPASS_EN
         assign w_byp  = RegWrite && !r_busy && (w_idx == write_reg);
`else
         assign w_byp  = 1'b0;
`endif
         assign read_data[gi*DATA_W +: DATA_W] =
            (r_busy || w_zero) ? '0 : (w_byp ? write_data : r_mem[w_idx]);
      end
   endgenerate

   assign init_busy  = r_busy;
   assign clear_done = r_done;

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Randomised bench for mips_regfile_mp: two instances (ZERO_REG=1 and ZERO_REG=0) share stimulus
// and are compared every cycle against a behavioural model, plus directed literal checks.
module tb_mips_regfile_mp;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int DEPTH = 1 << AW;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           rw = 1'b0;
   logic [AW-1:0]  wr = '0;
   logic [DW-1:0]  wd = '0;
   logic [NR*AW-1:0] rr = '0;
   logic [NR*DW-1:0] rd1, rd0;
   logic           busy1, done1, busy0, done0;

   int total = 0;
   int bad = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   mips_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1)) dut_zr1 (
      .clock(clk), .reset(reset), .RegWrite(rw), .write_reg(wr), .write_data(wd),
      .read_reg(rr), .read_data(rd1), .init_busy(busy1), .clear_done(done1));

   mips_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(0)) dut_zr0 (
      .clock(clk), .reset(reset), .RegWrite(rw), .write_reg(wr), .write_data(wd),
      .read_reg(rr), .read_data(rd0), .init_busy(busy0), .clear_done(done0));

`ifdef MIPS_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // Model: a countdown of remaining clear cycles; the whole file is zeroed when it expires.
   int          clr_left = DEPTH;
   bit          m_done = 0;
   bit [DW-1:0] m_mem [DEPTH];
   bit [DW-1:0] m_r0_zr0 = 0;

   always @(posedge clk) begin
      if (reset) begin
         clr_left = DEPTH;
         m_done   = 0;
      end else if (clr_left > 0) begin
         clr_left = clr_left - 1;
         m_done   = (clr_left == 0);
         if (clr_left == 0) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
            m_r0_zr0 = 0;
         end
      end else begin
         m_done = 0;
         if (rw) begin
            if (wr != 0) m_mem[wr] = wd;
            else         m_r0_zr0 = wd;
         end
      end
   end

   function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] idx, input bit zr);
      if (clr_left > 0) return '0;
      if (zr && idx == 0) return '0;
      if (BYP && rw && idx == wr) return wd;
      if (idx == 0) return m_r0_zr0;
      return m_mem[idx];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare process.
   always @(negedge clk) begin
      if (chk_en) begin
         #1;
         chk("busy_zr1", 64'(busy1), 64'(clr_left > 0));
         chk("busy_zr0", 64'(busy0), 64'(clr_left > 0));
         chk("done_zr1", 64'(done1), 64'(m_done));
         chk("done_zr0", 64'(done0), 64'(m_done));
         for (int k = 0; k < NR; k++) begin
            chk($sformatf("rd_zr1_p%0d", k), 64'(rd1[k*DW +: DW]), 64'(exp_read(rr[k*AW +: AW], 1'b1)));
            chk($sformatf("rd_zr0_p%0d", k), 64'(rd0[k*DW +: DW]), 64'(exp_read(rr[k*AW +: AW], 1'b0)));
         end
      end
   end

   // Counts busy samples and done pulses from the current negedge; optional write during clear.
   task automatic watch_clear(input int n, input int inj_at, output int busy_cnt,
                              output int done_at, output int done_cnt);
      busy_cnt = 0; done_at = -1; done_cnt = 0;
      for (int k = 0; k < n; k++) begin
         if (k == inj_at) begin rw = 1'b1; wr = 5'd7; wd = 32'hAAAA5555; end
         else rw = 1'b0;
         #2;
         if (busy1) busy_cnt++;
         if (done1) begin done_cnt++; if (done_at < 0) done_at = k; end
         @(negedge clk);
      end
      rw = 1'b0;
   endtask

   int bc, da, dc, dc_pre;

   initial begin
      @(posedge clk);
      chk_en = 1;
      @(negedge clk);
      #2;
      chk("reset_busy", 64'(busy1), 64'd1);
      chk("reset_done", 64'(done1), 64'd0);
      chk("reset_rd", 64'(rd1), 64'd0);
      reset = 1'b0;
      $display("txn: reset released, clear starts");

      watch_clear(40, 10, bc, da, dc);
      chk("clear_busy_cycles", 64'(bc), 64'd32);
      chk("clear_done_cycle", 64'(da), 64'd32);
      chk("clear_done_count", 64'(dc), 64'd1);
      $display("txn: clear busy=%0d done_at=%0d", bc, da);

      for (int i = 0; i < DEPTH; i++) begin
         rr = {5'd0, 5'(i)};
         #2;
         chk($sformatf("cleared_r%0d", i), 64'(rd0[DW-1:0]), 64'd0);
         @(negedge clk);
      end
      rr = {5'd7, 5'd7};
      #2;
      chk("r7_after_clear_write", 64'(rd1[DW-1:0]), 64'd0);

      @(negedge clk);
      rw = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF;
      @(negedge clk);
      rw = 1'b0; rr = {5'd5, 5'd5};
      #2;
      chk("r5_port0", 64'(rd1[DW-1:0]), 64'hDEADBEEF);
      chk("r5_port1", 64'(rd1[2*DW-1:DW]), 64'hDEADBEEF);
      $display("txn: write r5=deadbeef, read back %h/%h", rd1[DW-1:0], rd1[2*DW-1:DW]);

      @(negedge clk);
      rw = 1'b1; wr = 5'd0; wd = 32'h12345678;
      @(negedge clk);
      rw = 1'b0; rr = {5'd0, 5'd0};
      #2;
      chk("r0_zero_reg1", 64'(rd1[DW-1:0]), 64'd0);
      chk("r0_zero_reg0", 64'(rd0[DW-1:0]), 64'h12345678);
      $display("txn: write r0=12345678, zr1=%h zr0=%h", rd1[DW-1:0], rd0[DW-1:0]);

      @(negedge clk);
      rw = 1'b1; wr = 5'd9; wd = 32'h0000CAFE; rr = {5'd5, 5'd9};
      #2;
      chk("r9_write_cycle", 64'(rd1[DW-1:0]), BYP ? 64'h0000CAFE : 64'd0);
      @(negedge clk);
      rw = 1'b0;
      #2;
      chk("r9_next_cycle", 64'(rd1[DW-1:0]), 64'h0000CAFE);
      $display("txn: same-cycle r9 write/read, bypass=%0d", BYP);

      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 99) == 0);
         rw = $urandom_range(0, 1);
         wr = 5'($urandom_range(0, 31));
         wd = $urandom;
         for (int k = 0; k < NR; k++)
            rr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         $display("txn: rnd c=%0d rst=%0d we=%0d wr=%0d wd=%h rr=%h", c, reset, rw, wr, wd, rr);
      end

      @(negedge clk);
      reset = 1'b1; rw = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      watch_clear(20, -1, bc, da, dc_pre);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      watch_clear(40, -1, bc, da, dc);
      chk("restart_busy_cycles", 64'(bc), 64'd32);
      chk("restart_done_cycle", 64'(da), 64'd32);
      chk("restart_done_count", 64'(dc + dc_pre), 64'd1);
      $display("txn: reset at clear cycle 20, busy=%0d done_at=%0d", bc, da);

      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         rw = $urandom_range(0, 1);
         wr = 5'($urandom_range(0, 31));
         wd = $urandom;
         rr = 10'($urandom);
         $display("txn: rnd2 c=%0d we=%0d wr=%0d wd=%h rr=%h", c, rw, wr, wd, rr);
      end
      @(negedge clk);
      #3;
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
